output_forward_mac: RTL and testbench

//  Forward-pass output neuron, directly upstream of the output-layer backprop stage.

---
 rtl/nn_pkg.sv | 15 +
 rtl/act_buffer.sv | 37 +++
 rtl/output_forward_mac.sv | 90 +++++++++
 tb/tb_output_forward_mac.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths and FSM encoding for the forward-pass output neuron.
package nn_pkg;

    localparam int HID_W   = 10;
    localparam int WGT_W   = 8;
    localparam int PROD_W  = HID_W + WGT_W;
    localparam int FINAL_W = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/act_buffer.sv
// Hidden-activation register file: one synchronous write port, one async read port.
module act_buffer
    import nn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [HID_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [HID_W-1:0] rdata_o
);

    logic [HID_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_i == IDX_W'(i)) mem[i] <= wdata_i;
            end
        end
    end

    // Decoded mux so out-of-range addresses fall through to zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_i == IDX_W'(i)) rdata_o = mem[i];
        end
    end

endmodule

// File: rtl/output_forward_mac.sv
// Output neuron forward pass: serial h*w MAC over N_HIDDEN pairs with activation replay buffer.
module output_forward_mac
    import nn_pkg::*;
#(
    parameter int N_HIDDEN = 4,
    parameter int IDX_W    = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [HID_W-1:0]   hidden_i,
    input  logic [WGT_W-1:0]   w_i,
    output logic [FINAL_W-1:0] final_o,
    output logic               final_valid_o,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [HID_W-1:0]   hidden_val_o,
    output logic               busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

    state_t              state;
    logic [FINAL_W-1:0]  acc;
    logic [IDX_W-1:0]    idx;
    logic [PROD_W-1:0]   prod;
    logic                beat;
    logic                buf_we;

    assign in_ready_o    = (state == ACCUM);
    assign busy_o        = (state == ACCUM);
    assign final_valid_o = (state == DONE);
    assign final_o       = acc;

    assign beat   = in_valid_i & in_ready_o;
    // An abort in the same cycle discards the beat, including its buffer write.
    assign buf_we = beat & ~start_i;
    assign prod   = {{WGT_W{1'b0}}, hidden_i} * {{HID_W{1'b0}}, w_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (start_i) begin
                        acc <= '0;
                        idx <= '0;
                    end else if (in_valid_i) begin
                        acc <= acc + {{(FINAL_W-PROD_W){1'b0}}, prod};
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) state <= DONE;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    act_buffer #(
        .DEPTH (N_HIDDEN),
        .IDX_W (IDX_W)
    ) u_act_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (buf_we),
        .waddr_i (idx),
        .wdata_i (hidden_i),
        .raddr_i (rd_idx_i),
        .rdata_o (hidden_val_o)
    );

endmodule

// File: tb/tb_output_forward_mac.sv
// Directed bench for output_forward_mac (N=4 and N=32 instances).
module tb_output_forward_mac;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  hidden;
    logic [7:0]  w;
    logic [22:0] final_v;
    logic        final_valid;
    logic [4:0]  rd_idx;
    logic [9:0]  hidden_val;
    logic        busy;

    logic        start32;
    logic        in_valid32;
    logic        in_ready32;
    logic [22:0] final32;
    logic        final_valid32;
    logic [9:0]  hidden_val32;
    logic        busy32;

    int checks = 0;
    int errors = 0;

    output_forward_mac #(.N_HIDDEN(4), .IDX_W(5)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .hidden_i      (hidden),
        .w_i           (w),
        .final_o       (final_v),
        .final_valid_o (final_valid),
        .rd_idx_i      (rd_idx),
        .hidden_val_o  (hidden_val),
        .busy_o        (busy)
    );

    output_forward_mac #(.N_HIDDEN(32), .IDX_W(5)) dut32 (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start32),
        .in_valid_i    (in_valid32),
        .in_ready_o    (in_ready32),
        .hidden_i      (hidden),
        .w_i           (w),
        .final_o       (final32),
        .final_valid_o (final_valid32),
        .rd_idx_i      (rd_idx),
        .hidden_val_o  (hidden_val32),
        .busy_o        (busy32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [9:0] h, input logic [7:0] wt);
        in_valid = 1'b1;
        hidden   = h;
        w        = wt;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int gaps;
        logic [9:0] exp_rd [6];
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; hidden = '0; w = '0; rd_idx = '0;
        start32 = 1'b0; in_valid32 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_final", final_v, 0);
        chk("rst_valid", final_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hval", hidden_val, 0);

        // Inputs in IDLE without start are ignored
        beat(10'd7, 8'd7);
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_acc", final_v, 0);

        // Test 1: back-to-back pairs -> 107
        pulse_start();
        chk("t1_ready", in_ready, 1);
        chk("t1_busy", busy, 1);
        beat(10'd1, 8'd1);
        beat(10'd2, 8'd3);
        beat(10'd10, 8'd10);
        chk("t1_valid_before_last", final_valid, 0);
        chk("t1_partial", final_v, 107);
        beat(10'd0, 8'd255);
        chk("t1_final", final_v, 107);
        chk("t1_valid", final_valid, 1);
        chk("t1_ready_done", in_ready, 0);
        chk("t1_busy_done", busy, 0);

        // Test 6: replay sweep
        exp_rd[0] = 10'd1; exp_rd[1] = 10'd2; exp_rd[2] = 10'd10;
        exp_rd[3] = 10'd0; exp_rd[4] = 10'd0; exp_rd[5] = 10'd0;
        for (int i = 0; i < 6; i++) begin
            rd_idx = 5'(i);
            #1;
            chk($sformatf("t6_rd%0d", i), hidden_val, exp_rd[i]);
        end
        rd_idx = 5'd31;
        #1;
        chk("t6_rd31", hidden_val, 0);

        // DONE ignores pairs and holds the result
        beat(10'd100, 8'd100);
        chk("done_hold_final", final_v, 107);
        chk("done_hold_valid", final_valid, 1);

        // Test 2: max pairs with random gaps -> 1,043,460
        pulse_start();
        chk("t2_valid_fall", final_valid, 0);
        chk("t2_acc_clear", final_v, 0);
        rd_idx = 5'd2;
        #1;
        chk("t2_buf_persist", hidden_val, 10);
        for (int i = 0; i < 4; i++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                chk("t2_ready_gap", in_ready, 1);
                tick();
            end
            chk("t2_ready_beat", in_ready, 1);
            beat(10'd1023, 8'd255);
            if (i == 0) begin
                rd_idx = 5'd0;
                #1;
                chk("t2_overwrite0", hidden_val, 1023);
                rd_idx = 5'd1;
                #1;
                chk("t2_keep1", hidden_val, 2);
            end
        end
        chk("t2_final", final_v, 1043460);
        chk("t2_valid", final_valid, 1);

        // Test 4: abort after two beats, start wins over a same-cycle beat
        pulse_start();
        beat(10'd7, 8'd7);
        beat(10'd7, 8'd7);
        chk("t4_partial", final_v, 98);
        start = 1'b1;
        beat(10'd99, 8'd99);
        start = 1'b0;
        chk("t4_abort_clear", final_v, 0);
        chk("t4_abort_busy", busy, 1);
        rd_idx = 5'd2;
        #1;
        chk("t4_dropped_write", hidden_val, 1023);
        for (int i = 0; i < 4; i++) beat(10'd5, 8'd2);
        chk("t4_final", final_v, 40);
        chk("t4_valid", final_valid, 1);
        rd_idx = 5'd3;
        #1;
        chk("t4_buf3", hidden_val, 5);

        // Test 3: N=32 full-scale, no wrap
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        in_valid32 = 1'b1;
        hidden = 10'd1023;
        w = 8'd255;
        repeat (31) tick();
        chk("t3_valid_before_last", final_valid32, 0);
        tick();
        in_valid32 = 1'b0;
        chk("t3_final", final32, 8347680);
        chk("t3_valid", final_valid32, 1);
        rd_idx = 5'd31;
        #1;
        chk("t3_buf31", hidden_val32, 1023);

        // Test 5: async reset mid-ACCUM
        pulse_start();
        beat(10'd3, 8'd4);
        beat(10'd5, 8'd6);
        chk("t5_pre_rst_acc", final_v, 42);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_final", final_v, 0);
        chk("t5_rst_ready", in_ready, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", final_valid, 0);
        rd_idx = 5'd0;
        #1;
        chk("t5_rst_buf0", hidden_val, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_idle_busy", busy, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) beat(10'd1, 8'd1);
        chk("t5_after_final", final_v, 4);
        chk("t5_after_valid", final_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
